seg7_digit_driver: RTL and testbench

//  Downstream consumer of the 4-digit anode/select sequencer. Holds a 16-bit
//  hex display value plus per-digit decimal points. Decodes the nibble picked by
//  dsp_sel into active-low 7-segment drive and registers anodes and segments.

---
 rtl/seg7_pkg.sv | 10 +
 rtl/seg7_digit_driver_hex.sv | 9 +
 rtl/seg7_digit_driver.sv | 72 +++++++
 tb/tb_seg7_digit_driver.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and glyph table for the 7-segment digit driver
package seg7_pkg;
   localparam int NUM_DIGITS = 4;
   localparam logic [6:0] SEG_OFF = 7'h7F;
   // Active-high glyphs, bit order {g,f,e,d,c,b,a}, indexed by nibble value
   localparam logic [6:0] GLYPHS [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
endpackage

// File: rtl/seg7_digit_driver_hex.sv
// hex_to_seg7: combinational nibble to active-high 7-segment glyph
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   assign seg = GLYPHS[nib];
endmodule

// File: rtl/seg7_digit_driver.sv
// seg7_digit_driver: tear-free 4-digit hex display driver with anti-ghosting dead time
module seg7_digit_driver
   import seg7_pkg::*;
#(
   parameter int         DEAD_CYCLES     = 2,
   parameter logic [1:0] FRAME_START_SEL = 2'd3
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            dsp_sel,
   input  logic [3:0]            an_in,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [15:0]           load_data,
   input  logic [NUM_DIGITS-1:0] load_dp,
   input  logic                  blank_lz,
   output logic [3:0]            an_out,
   output logic [6:0]            seg_n,
   output logic                  dp_n
);
   localparam int CW = DEAD_CYCLES > 0 ? $clog2(DEAD_CYCLES + 1) : 1;
   logic [15:0] act_val, pend_val;
   logic [NUM_DIGITS-1:0] act_dp, pend_dp;
   logic pend_full;
   logic [1:0] prev_sel;
   logic [3:0] prev_an;
   logic [CW-1:0] dead_cnt, dead_nxt;
   logic [3:0] nib;
   logic [6:0] glyph;
   logic boundary, accept, lz_blank, dead;
   assign load_ready = !pend_full;
   assign accept = load_valid && load_ready;
   assign boundary = dsp_sel != prev_sel && dsp_sel == FRAME_START_SEL;
   // Blanking covers the change cycle itself plus the following cycles until the count drains
   assign dead_nxt = an_in != prev_an ? CW'(DEAD_CYCLES) : dead_cnt != '0 ? dead_cnt - CW'(1) : '0;
   assign dead = dead_nxt != '0;
   assign nib = act_val[{dsp_sel, 2'b00} +: 4];
   assign lz_blank = blank_lz && dsp_sel != 2'd0 && (act_val >> {dsp_sel, 2'b00}) == 16'h0;
   hex_to_seg7 u_hex (.nib(nib), .seg(glyph));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_val   <= '0;
         act_dp    <= '0;
         pend_val  <= '0;
         pend_dp   <= '0;
         pend_full <= 1'b0;
         prev_sel  <= FRAME_START_SEL;
         prev_an   <= 4'hF;
         dead_cnt  <= '0;
         an_out    <= 4'hF;
         seg_n     <= SEG_OFF;
         dp_n      <= 1'b1;
      end else begin
         prev_sel <= dsp_sel;
         prev_an  <= an_in;
         dead_cnt <= dead_nxt;
         if (boundary && pend_full) begin
            act_val <= pend_val;
            act_dp  <= pend_dp;
         end
         if (accept) begin
            pend_val <= load_data;
            pend_dp  <= load_dp;
         end
         pend_full <= accept || (pend_full && !boundary);
         an_out    <= dead ? 4'hF : an_in;
         seg_n     <= dead || lz_blank ? SEG_OFF : ~glyph;
         dp_n      <= dead || !act_dp[dsp_sel];
      end
   end
endmodule

// File: tb/tb_seg7_digit_driver.sv
// tb_seg7_digit_driver: randomized scoreboard bench against a frame-level display model
module tb_seg7_digit_driver;
   localparam int D = 2;
   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] dsp_sel = 2'd0;
   logic [3:0] an_in = 4'hF;
   logic load_valid = 1'b0, blank_lz = 1'b0;
   logic [15:0] load_data = 16'h0;
   logic [3:0] load_dp = 4'h0;
   logic load_ready, dp_n;
   logic [3:0] an_out;
   logic [6:0] seg_n;
   seg7_digit_driver #(.DEAD_CYCLES(D), .FRAME_START_SEL(2'd3)) dut (
      .clk(clk), .rst(rst), .dsp_sel(dsp_sel), .an_in(an_in),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .load_dp(load_dp), .blank_lz(blank_lz), .an_out(an_out), .seg_n(seg_n), .dp_n(dp_n)
   );
   always #5 clk = ~clk;
   typedef struct {logic [3:0] an; logic [6:0] seg; logic dp; logic rdy;} exp_t;
   exp_t q[$];
   int checks = 0, failures = 0;
   string glyph_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                             "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
   logic [15:0] m_act, m_pend;
   logic [3:0] m_act_dp, m_pend_dp, m_pan;
   logic [1:0] m_psel;
   logic m_pfull;
   int cyc = 0, last_chg = -1000;
   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] s = 7'h0;
      for (int i = 0; i < glyph_str[n].len(); i++) s[int'(glyph_str[n][i]) - 97] = 1'b1;
      return s;
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("an_out", 32'(an_out), 32'(e.an));
         check("seg_n", 32'(seg_n), 32'(e.seg));
         check("dp_n", 32'(dp_n), 32'(e.dp));
         check("load_ready", 32'(load_ready), 32'(e.rdy));
      end
   end
   task automatic step(input logic [1:0] s, input logic [3:0] a, input logic v, input logic [15:0] d,
                       input logic [3:0] p, input logic b, input logic r);
      exp_t e;
      logic blank, lz, acc;
      logic [3:0] nib;
      @(negedge clk);
      dsp_sel = s; an_in = a; load_valid = v; load_data = d; load_dp = p; blank_lz = b; rst = r;
      if (r) begin
         m_act = 0; m_pend = 0; m_act_dp = 0; m_pend_dp = 0; m_pfull = 0;
         m_psel = 2'd3; m_pan = 4'hF; last_chg = -1000;
         e = '{4'hF, 7'h7F, 1'b1, 1'b1};
         #1;
         check("rst_an", 32'(an_out), 32'hF);
         check("rst_seg", 32'(seg_n), 32'h7F);
         check("rst_dp", 32'(dp_n), 32'h1);
      end else begin
         if (a != m_pan) last_chg = cyc;
         blank = cyc - last_chg < D;
         nib = 4'(m_act >> (4 * s));
         lz = b && s != 2'd0 && (m_act >> (4 * s)) == 16'h0;
         e.an = blank ? 4'hF : a;
         e.seg = (blank || lz) ? 7'h7F : ~glyph(nib);
         e.dp = blank || !m_act_dp[s];
         acc = v && !m_pfull;
         if (s != m_psel && s == 2'd3 && m_pfull) begin
            m_act = m_pend; m_act_dp = m_pend_dp; m_pfull = 0;
         end
         if (acc) begin
            m_pend = d; m_pend_dp = p; m_pfull = 1;
         end
         m_psel = s; m_pan = a;
         e.rdy = !m_pfull;
      end
      cyc++;
      q.push_back(e);
   endtask
   task automatic dwell(input logic [1:0] s, input int n, input int vmode, input logic [15:0] d,
                        input logic [3:0] p, input logic b);
      for (int i = 0; i < n; i++)
         step(s, ~(4'b1 << s), vmode == 2 || (vmode == 1 && i == 0), d, p, b, 1'b0);
   endtask
   task automatic frames(input int n, input logic b);
      for (int f = 0; f < n; f++)
         for (int s = 0; s < 4; s++) dwell(2'(s), 4, 0, 16'h0, 4'h0, b);
   endtask
   initial begin
      logic [1:0] s;
      step(2'd0, 4'hF, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
      step(2'd0, 4'hF, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
      // tear-free commit of 1234
      dwell(2'd0, 4, 1, 16'h1234, 4'b0001, 1'b0);
      dwell(2'd1, 4, 0, 16'h0, 4'h0, 1'b0);
      dwell(2'd2, 4, 0, 16'h0, 4'h0, 1'b0);
      dwell(2'd3, 4, 0, 16'h0, 4'h0, 1'b0);
      frames(1, 1'b0);
      // backpressure: A pending, B held until after the boundary
      dwell(2'd0, 2, 1, 16'hABCD, 4'b1000, 1'b0);
      dwell(2'd1, 3, 2, 16'h5E6F, 4'b0110, 1'b0);
      dwell(2'd2, 3, 2, 16'h5E6F, 4'b0110, 1'b0);
      dwell(2'd3, 4, 2, 16'h5E6F, 4'b0110, 1'b0);
      frames(2, 1'b0);
      // leading-zero blanking
      dwell(2'd0, 2, 1, 16'h0042, 4'b0100, 1'b1);
      frames(2, 1'b1);
      dwell(2'd0, 2, 1, 16'h0000, 4'b0000, 1'b1);
      frames(2, 1'b1);
      // accept on the boundary cycle commits a frame later
      dwell(2'd0, 3, 0, 16'h0, 4'h0, 1'b0);
      dwell(2'd1, 3, 0, 16'h0, 4'h0, 1'b0);
      dwell(2'd2, 3, 0, 16'h0, 4'h0, 1'b0);
      dwell(2'd3, 4, 1, 16'hC0DE, 4'b0101, 1'b0);
      frames(2, 1'b0);
      // held select: no boundary, second load stalls
      dwell(2'd1, 10, 2, 16'h9999, 4'hF, 1'b0);
      frames(1, 1'b0);
      s = 2'd0;
      for (int it = 0; it < 500; it++) begin
         logic b;
         int hold;
         b = 1'($urandom_range(0, 1));
         hold = $urandom_range(1, 5);
         if ($urandom_range(0, 9) != 0) s = s + 2'd1;
         if ($urandom_range(0, 149) == 0) begin
            step(s, 4'h0, 1'b0, 16'h0, 4'h0, b, 1'b1);
            step(s, 4'h0, 1'b0, 16'h0, 4'h0, b, 1'b1);
         end
         for (int h = 0; h < hold; h++)
            step(s, $urandom_range(0, 19) == 0 ? 4'hF : ~(4'b1 << s), $urandom_range(0, 3) == 0,
                 16'($urandom), 4'($urandom), b, 1'b0);
      end
      @(posedge clk);
      #2;
      check("drain", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
